// File: rtl/demux8x32_regbank.sv
// Eight-slot register bank written by decoded select, with byte enables,
// an auto-incrementing burst loader (valid/ready) and a synchronous clear.
module demux8x32_regbank #(
  parameter int unsigned           WIDTH     = 32,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               clr,
  input  logic               wr_en,
  input  logic [2:0]         wr_sel,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [WIDTH/8-1:0] wr_be,
  input  logic               burst_start,
  input  logic [3:0]         burst_len,
  input  logic               burst_valid,
  output logic               burst_ready,
  output logic               busy,
  output logic               wr_done,
  output logic [2:0]         last_sel,
  output logic [WIDTH-1:0]   Q0,
  output logic [WIDTH-1:0]   Q1,
  output logic [WIDTH-1:0]   Q2,
  output logic [WIDTH-1:0]   Q3,
  output logic [WIDTH-1:0]   Q4,
  output logic [WIDTH-1:0]   Q5,
  output logic [WIDTH-1:0]   Q6,
  output logic [WIDTH-1:0]   Q7
);

  // state | meaning
  // IDLE  | single writes, clear and burst start accepted
  // BURST | beats written to slot[ptr] on burst_valid, cnt beats remaining
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [2:0]       last_sel_q, last_sel_d;
  logic             wr_done_q, wr_done_d;
  logic [WIDTH-1:0] slot_q [8];
  logic [WIDTH-1:0] slot_d [8];

  function automatic logic [WIDTH-1:0] merge_be(input logic [WIDTH-1:0]   old_val,
                                                input logic [WIDTH-1:0]   new_val,
                                                input logic [WIDTH/8-1:0] be);
    logic [WIDTH-1:0] res;
    res = old_val;
    for (int i = 0; i < WIDTH / 8; i++) begin
      if (be[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    last_sel_d = last_sel_q;
    wr_done_d  = 1'b0;
    for (int i = 0; i < 8; i++) slot_d[i] = slot_q[i];

    unique case (state_q)
      IDLE: begin
        if (clr) begin
          for (int i = 0; i < 8; i++) slot_d[i] = RESET_VAL;
        end else if (burst_start) begin
          if (burst_len == 4'd0) begin
            wr_done_d = 1'b1;
          end else begin
            ptr_d   = wr_sel;
            cnt_d   = (burst_len > 4'd8) ? 4'd8 : burst_len;
            state_d = BURST;
          end
        end else if (wr_en) begin
          slot_d[wr_sel] = merge_be(slot_q[wr_sel], wr_data, wr_be);
          last_sel_d     = wr_sel;
          wr_done_d      = 1'b1;
        end
      end
      BURST: begin
        // clr aborts the burst and wins over a beat in the same cycle
        if (clr) begin
          for (int i = 0; i < 8; i++) slot_d[i] = RESET_VAL;
          state_d = IDLE;
        end else if (burst_valid) begin
          slot_d[ptr_q] = merge_be(slot_q[ptr_q], wr_data, wr_be);
          last_sel_d    = ptr_q;
          ptr_d         = ptr_q + 3'd1;
          cnt_d         = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d   = IDLE;
            wr_done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      ptr_q      <= 3'd0;
      cnt_q      <= 4'd0;
      last_sel_q <= 3'd0;
      wr_done_q  <= 1'b0;
      for (int i = 0; i < 8; i++) slot_q[i] <= RESET_VAL;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      last_sel_q <= last_sel_d;
      wr_done_q  <= wr_done_d;
      for (int i = 0; i < 8; i++) slot_q[i] <= slot_d[i];
    end
  end

  assign burst_ready = (state_q == BURST);
  assign busy        = (state_q == BURST);
  assign wr_done     = wr_done_q;
  assign last_sel    = last_sel_q;

  assign Q0 = slot_q[0];
  assign Q1 = slot_q[1];
  assign Q2 = slot_q[2];
  assign Q3 = slot_q[3];
  assign Q4 = slot_q[4];
  assign Q5 = slot_q[5];
  assign Q6 = slot_q[6];
  assign Q7 = slot_q[7];

endmodule

// File: tb/tb_demux8x32_regbank.sv
// Directed bench for demux8x32_regbank: inputs driven and outputs checked
// on the falling edge, expected values hand-computed.
module tb_demux8x32_regbank;

  logic        clk = 1'b0;
  logic        resetn, clr, wr_en, burst_start, burst_valid;
  logic [2:0]  wr_sel;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic [3:0]  burst_len;
  logic        burst_ready, busy, wr_done;
  logic [2:0]  last_sel;
  logic [31:0] q0, q1, q2, q3, q4, q5, q6, q7;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  demux8x32_regbank dut (
    .clk(clk), .resetn(resetn), .clr(clr), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_data(wr_data), .wr_be(wr_be), .burst_start(burst_start),
    .burst_len(burst_len), .burst_valid(burst_valid), .burst_ready(burst_ready),
    .busy(busy), .wr_done(wr_done), .last_sel(last_sel),
    .Q0(q0), .Q1(q1), .Q2(q2), .Q3(q3), .Q4(q4), .Q5(q5), .Q6(q6), .Q7(q7)
  );

  function automatic logic [31:0] qv(input int i);
    case (i)
      0: return q0;  1: return q1;  2: return q2;  3: return q3;
      4: return q4;  5: return q5;  6: return q6;  default: return q7;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    clr = 0; wr_en = 0; burst_start = 0; burst_valid = 0;
  endtask

  int beats, dones;

  initial begin
    resetn = 0; idle_inputs(); wr_sel = 0; wr_data = 0; wr_be = 4'hF; burst_len = 0;
    step(); step();
    for (int i = 0; i < 8; i++) chk($sformatf("rst_q%0d", i), qv(i), 32'h0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", burst_ready, 0);
    chk("rst_done", wr_done, 0);
    chk("rst_last", last_sel, 0);
    resetn = 1;
    step();

    // single full write
    wr_en = 1; wr_sel = 5; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
    step();
    wr_en = 0;
    chk("single_q5", q5, 32'hDEADBEEF);
    chk("single_q4", q4, 32'h0);
    chk("single_last", last_sel, 5);
    chk("single_done", wr_done, 1);
    step();
    chk("single_done_off", wr_done, 0);

    // byte-enable merge, back-to-back writes
    wr_en = 1; wr_sel = 2; wr_data = 32'h11223344; wr_be = 4'hF;
    step();
    chk("merge_pre_q2", q2, 32'h11223344);
    chk("merge_done1", wr_done, 1);
    wr_data = 32'hAABBCCDD; wr_be = 4'h5;
    step();
    wr_en = 0; wr_be = 4'hF;
    chk("merge_q2", q2, 32'h11BB33DD);
    chk("merge_done2", wr_done, 1);
    step();

    // burst with wrap and a stall; start-cycle data must not be written
    burst_start = 1; wr_sel = 6; burst_len = 3; wr_data = 32'hFFFF;
    step();
    burst_start = 0;
    chk("b_busy0", busy, 1);
    chk("b_ready0", burst_ready, 1);
    chk("b_q6_nostart", q6, 32'h0);
    burst_valid = 1; wr_data = 32'hA;
    step();
    chk("b_q6", q6, 32'hA);
    chk("b_busy1", busy, 1);
    burst_valid = 0; wr_en = 1; wr_sel = 3; wr_data = 32'h333;
    step();
    chk("b_busy_stall", busy, 1);
    chk("b_q7_stall", q7, 32'h0);
    chk("b_done_stall", wr_done, 0);
    wr_en = 0; burst_valid = 1; wr_data = 32'hB;
    step();
    chk("b_q7", q7, 32'hB);
    chk("b_busy3", busy, 1);
    wr_data = 32'hC;
    step();
    burst_valid = 0;
    chk("b_q0", q0, 32'hC);
    chk("b_busy_end", busy, 0);
    chk("b_done", wr_done, 1);
    chk("b_last", last_sel, 0);
    chk("b_q3_ignored", q3, 32'h0);
    step();
    chk("b_done_off", wr_done, 0);

    // zero-length burst
    burst_start = 1; burst_len = 0; wr_sel = 1; wr_data = 32'h5555;
    step();
    burst_start = 0;
    chk("z_done", wr_done, 1);
    chk("z_busy", busy, 0);
    chk("z_q1", q1, 32'h0);
    chk("z_q6", q6, 32'hA);
    step();
    chk("z_done_off", wr_done, 0);

    // oversize burst saturates to 8 beats
    burst_start = 1; burst_len = 12; wr_sel = 0;
    step();
    burst_start = 0; burst_valid = 1;
    beats = 0; dones = 0;
    for (int i = 0; i < 12; i++) begin
      wr_data = 32'h100 + i;
      if (burst_ready) beats++;
      if (wr_done) dones++;
      step();
    end
    burst_valid = 0;
    chk("sat_beats", beats, 8);
    chk("sat_dones", dones, 1);
    chk("sat_q0", q0, 32'h100);
    chk("sat_q5", q5, 32'h105);
    chk("sat_q7", q7, 32'h107);
    chk("sat_last", last_sel, 7);
    chk("sat_busy", busy, 0);

    // clr mid-burst, together with a valid beat
    burst_start = 1; burst_len = 4; wr_sel = 0;
    step();
    burst_start = 0; burst_valid = 1; wr_data = 32'h55;
    step();
    chk("c_q0_beat", q0, 32'h55);
    clr = 1; wr_data = 32'h66;
    step();
    clr = 0; burst_valid = 0;
    for (int i = 0; i < 8; i++) chk($sformatf("c_q%0d", i), qv(i), 32'h0);
    chk("c_busy", busy, 0);
    chk("c_ready", burst_ready, 0);
    chk("c_done", wr_done, 0);
    step();
    chk("c_done_later", wr_done, 0);

    // reset mid-burst
    burst_start = 1; burst_len = 4; wr_sel = 2;
    step();
    burst_start = 0; burst_valid = 1; wr_data = 32'h99;
    step();
    chk("r_q2_beat", q2, 32'h99);
    chk("r_last_beat", last_sel, 2);
    resetn = 0;
    step();
    resetn = 1; burst_valid = 0;
    chk("r_q2", q2, 32'h0);
    chk("r_busy", busy, 0);
    chk("r_ready", burst_ready, 0);
    chk("r_last", last_sel, 0);
    chk("r_done", wr_done, 0);

    // single write after reset, partial byte enables
    wr_en = 1; wr_sel = 4; wr_data = 32'h12345678; wr_be = 4'h3;
    step();
    chk("p_q4", q4, 32'h00005678);
    chk("p_last", last_sel, 4);
    chk("p_done", wr_done, 1);

    // wr_be = 0 changes nothing but still completes
    wr_sel = 1; wr_data = 32'hFFFFFFFF; wr_be = 4'h0;
    step();
    wr_en = 0;
    chk("be0_q1", q1, 32'h0);
    chk("be0_done", wr_done, 1);
    chk("be0_last", last_sel, 1);
    step();
    chk("be0_done_off", wr_done, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/demux8x32_regbank.md
Name: demux8x32_regbank

Overview:
- Write-side counterpart of the 8:1 32-bit read mux: decodes a 3-bit select and stores data into one of eight registered 32-bit slots, Q0..Q7.
- Q0..Q7 drive the mux's A0..A7 inputs directly.
- Supports single byte-enabled writes, an auto-incrementing burst load with a valid/ready handshake, and a synchronous clear-all.
- Used for the CP0 and exception-vector slot banks in the single-cycle CPU.

Parameters:
- WIDTH, 32, slot data width; must be a multiple of 8.
- RESET_VAL, 0, value loaded into every slot on reset and on clr.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- resetn  input  1  reset, synchronous, active-low.
- clr  input  1  synchronous clear of all slots to RESET_VAL.
- wr_en  input  1  single-write strobe; honoured only in IDLE.
- wr_sel  input  3  target slot for a single write; start slot for a burst.
- wr_data  input  WIDTH  write data, shared by single and burst writes.
- wr_be  input  WIDTH/8  byte enables; bit i covers byte i. Applies to both write modes.
- burst_start  input  1  begins a burst in IDLE.
- burst_len  input  4  burst beat count, sampled with burst_start.
- burst_valid  input  1  burst beat present on wr_data.
- burst_ready  output  1  block accepts a beat this cycle.
- busy  output  1  high in the BURST state.
- wr_done  output  1  one-cycle pulse after any completed write or burst.
- last_sel  output  3  slot index of the most recent written beat.
- Q0..Q7  output  WIDTH each  registered slot contents.

Behaviour:
- Reset (resetn=0 at a clock edge):
  - Q0..Q7 = RESET_VAL; state = IDLE; busy=0; burst_ready=0; wr_done=0; last_sel=0.
  - Reset overrides everything, including an in-progress burst.
- Write latency: a write accepted at edge N is visible on Q at edge N, i.e. readable one cycle after the strobe. Q never changes combinationally.
- Byte enables: only bytes with wr_be[i]=1 are updated; others hold. wr_be=0 performs no data change but still pulses wr_done.
- States are IDLE and BURST.
- IDLE priority, per cycle: clr > burst_start > wr_en.
  - clr: all slots = RESET_VAL; no wr_done; last_sel holds.
  - burst_start with burst_len=0: no-op, wr_done pulses next cycle, stay IDLE.
  - burst_start with burst_len 1..8: latch ptr=wr_sel and cnt=burst_len, go to BURST. wr_data in this cycle is not written.
  - burst_start with burst_len >8: saturates to 8.
  - wr_en: slot[wr_sel] updated per wr_be; last_sel=wr_sel; wr_done=1 next cycle.
- BURST:
  - burst_ready=1 and busy=1 for the whole state.
  - Beat accepted when burst_valid=1. Then slot[ptr] updated per wr_be, last_sel=ptr, ptr=ptr+1 mod 8 (7 wraps to 0), cnt=cnt-1.
  - burst_valid=0: stall, nothing changes.
  - Last beat (cnt=1 accepted): next state IDLE, wr_done=1 for one cycle in that next cycle, busy=0.
  - wr_en and burst_start are ignored.
  - clr: clears all slots, aborts to IDLE, no wr_done. clr has priority over a beat in the same cycle.
- wr_done is registered and high for exactly one cycle per completed operation. Back-to-back single writes give consecutive pulses.

Test Plan:
- Reset then single write: wr_en=1, wr_sel=5, wr_data=0xDEADBEEF, wr_be=0xF → next cycle Q5=0xDEADBEEF, other slots 0, last_sel=5, wr_done pulses once.
- Byte-enable merge: Q2=0x11223344, then write 0xAABBCCDD with wr_be=0x5 → Q2=0x11BB33DD.
- Burst with wrap: wr_sel=6, burst_len=3, beats 0xA, 0xB, 0xC with one burst_valid=0 stall between the first and second beats → Q6=0xA, Q7=0xB, Q0=0xC. busy high for 4 cycles; wr_done pulses after beat 3; last_sel=0.
- Ignored inputs during burst: wr_en=1 to slot 3 while busy → Q3 unchanged. Also burst_len=0 → no slot change, one wr_done; burst_len=12 → exactly 8 beats accepted.
- clr mid-burst: after 1 of 4 beats, assert clr together with burst_valid → all Q = RESET_VAL, state IDLE, burst_ready=0, no wr_done.
- Reset mid-burst: resetn=0 while busy → next cycle all outputs at reset values. A following single write works normally.
